// File: rtl/v_noc_scoreboard_mp.sv
// v_noc_scoreboard_mp: multi-port NoC scoreboard. It tracks in-flight flits
// from send to receive, retires stuck entries by timeout and keeps inflight,
// timeout and latency statistics.
// Optional macro V_NOC_SB_TXN_ID_EN: store the txn id per entry, add it to the
// match key and flag duplicate txn ids from the same source.
module v_noc_scoreboard_mp #(
  parameter int ENTRY_NUM    = 16,
  parameter int REC_PORT_NUM = 2,
  parameter int TIMEOUT_W    = 15,
  parameter int DATA_W       = 32,
  parameter int NODE_ID_W    = 4,
  parameter int TXN_W        = 8,
  localparam int AW          = $clog2(ENTRY_NUM),
  localparam int CW          = AW + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           alloc_vld_i,
  output logic                           alloc_rdy_o,
  input  logic [NODE_ID_W-1:0]           alloc_src_id_i,
  input  logic [NODE_ID_W-1:0]           alloc_tgt_id_i,
  input  logic [TXN_W-1:0]               alloc_txn_id_i,
  input  logic [DATA_W-1:0]              alloc_data_i,
  input  logic [TIMEOUT_W-1:0]           alloc_timeout_i,
  output logic [AW-1:0]                  alloc_idx_o,
  input  logic [REC_PORT_NUM-1:0]        rec_vld_i,
  input  logic [REC_PORT_NUM*NODE_ID_W-1:0] rec_id_i,
  input  logic [REC_PORT_NUM*NODE_ID_W-1:0] rec_src_id_i,
  input  logic [REC_PORT_NUM*TXN_W-1:0]  rec_txn_id_i,
  input  logic [REC_PORT_NUM*DATA_W-1:0] rec_data_i,
  output logic [REC_PORT_NUM-1:0]        rec_hit_o,
  output logic [REC_PORT_NUM-1:0]        rec_err_o,
  output logic                           timeout_o,
  output logic [AW-1:0]                  timeout_idx_o,
  output logic [CW-1:0]                  inflight_cnt_o,
  output logic [31:0]                    timeout_cnt_o,
  output logic [63:0]                    max_latency_o
);

  logic [ENTRY_NUM-1:0] valid, valid_nxt, alloc_oh, claimed, expire;
  logic [NODE_ID_W-1:0] src_q   [ENTRY_NUM];
  logic [NODE_ID_W-1:0] tgt_q   [ENTRY_NUM];
  logic [DATA_W-1:0]    data_q  [ENTRY_NUM];
  logic [TIMEOUT_W-1:0] thr_q   [ENTRY_NUM];
  logic [TIMEOUT_W-1:0] timer_q [ENTRY_NUM];
  logic [63:0]          sent_q  [ENTRY_NUM];
  logic [63:0]          mcycle;
  logic [AW-1:0]        free_idx, to_idx;
  logic [CW-1:0]        to_num, inflight_nxt;
  logic                 alloc_fire;
  logic [ENTRY_NUM-1:0] cand  [REC_PORT_NUM];
  logic [ENTRY_NUM-1:0] avail [REC_PORT_NUM];
  logic [AW-1:0]        port_idx [REC_PORT_NUM];
  logic [REC_PORT_NUM-1:0] port_hit;
  logic [63:0]          lat [REC_PORT_NUM];
  logic [63:0]          lat_max;
  logic [32:0]          cnt_sum;

`ifdef V_NOC_SB_TXN_ID_EN
  logic [TXN_W-1:0]     txn_q [ENTRY_NUM];
  logic                 dup_now, dup_txn;
`else
  logic                 unused_txn;
  assign unused_txn = ^{alloc_txn_id_i, rec_txn_id_i};
`endif

  assign alloc_rdy_o = ~&valid;
  assign alloc_fire  = alloc_vld_i & alloc_rdy_o;
  assign alloc_idx_o = alloc_fire ? free_idx : '0;

  // Lowest free entry and its one-hot grant.
  always_comb begin
    free_idx = '0;
    alloc_oh = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--)
      if (!valid[i]) free_idx = AW'(i);
    for (int i = 0; i < ENTRY_NUM; i++)
      alloc_oh[i] = alloc_fire && (free_idx == AW'(i));
  end

  // Candidate entries per receive port.
  always_comb begin
    logic txn_ok;
    txn_ok = 1'b1;
    for (int p = 0; p < REC_PORT_NUM; p++) begin
      cand[p] = '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
`ifdef V_NOC_SB_TXN_ID_EN
        txn_ok = txn_q[i] == rec_txn_id_i[p*TXN_W +: TXN_W];
`endif
        cand[p][i] = rec_vld_i[p] && valid[i] && txn_ok &&
                     (tgt_q[i]  == rec_id_i[p*NODE_ID_W +: NODE_ID_W]) &&
                     (src_q[i]  == rec_src_id_i[p*NODE_ID_W +: NODE_ID_W]) &&
                     (data_q[i] == rec_data_i[p*DATA_W +: DATA_W]);
      end
    end
  end

  // Ports claim entries in port order; later ports skip entries already taken.
  always_comb begin
    claimed  = '0;
    port_hit = '0;
    for (int p = 0; p < REC_PORT_NUM; p++) begin
      port_idx[p] = '0;
      avail[p]    = cand[p] & ~claimed;
      for (int i = ENTRY_NUM - 1; i >= 0; i--)
        if (avail[p][i]) begin
          port_idx[p] = AW'(i);
          port_hit[p] = 1'b1;
        end
      if (port_hit[p]) claimed[port_idx[p]] = 1'b1;
    end
  end

  // Largest send-to-receive latency among this cycle's hits.
  always_comb begin
    lat_max = '0;
    for (int p = 0; p < REC_PORT_NUM; p++) begin
      lat[p] = mcycle - sent_q[port_idx[p]];
      if (port_hit[p] && (lat[p] > lat_max)) lat_max = lat[p];
    end
  end

  // Expiring entries; a same-cycle hit takes precedence over the timeout.
  always_comb begin
    expire = '0;
    to_idx = '0;
    to_num = '0;
    for (int i = 0; i < ENTRY_NUM; i++)
      expire[i] = valid[i] && (thr_q[i] != '0) && !claimed[i] &&
                  ((timer_q[i] + TIMEOUT_W'(1)) == thr_q[i]);
    for (int i = ENTRY_NUM - 1; i >= 0; i--)
      if (expire[i]) to_idx = AW'(i);
    for (int i = 0; i < ENTRY_NUM; i++)
      to_num = to_num + CW'(expire[i]);
  end

  // Next valid vector and its population count.
  always_comb begin
    valid_nxt    = (valid & ~claimed & ~expire) | alloc_oh;
    inflight_nxt = '0;
    for (int i = 0; i < ENTRY_NUM; i++)
      inflight_nxt = inflight_nxt + CW'(valid_nxt[i]);
    cnt_sum = {1'b0, timeout_cnt_o} + 33'(to_num);
  end

  // Entry storage, per-entry timers and the free-running cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= '0;
      mcycle <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        src_q[i]   <= '0;
        tgt_q[i]   <= '0;
        data_q[i]  <= '0;
        thr_q[i]   <= '0;
        timer_q[i] <= '0;
        sent_q[i]  <= '0;
`ifdef V_NOC_SB_TXN_ID_EN
        txn_q[i]   <= '0;
`endif
      end
    end else begin
      mcycle <= mcycle + 64'd1;
      valid  <= valid_nxt;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (alloc_oh[i]) begin
          src_q[i]   <= alloc_src_id_i;
          tgt_q[i]   <= alloc_tgt_id_i;
          data_q[i]  <= alloc_data_i;
          thr_q[i]   <= alloc_timeout_i;
          timer_q[i] <= '0;
          sent_q[i]  <= mcycle;
`ifdef V_NOC_SB_TXN_ID_EN
          txn_q[i]   <= alloc_txn_id_i;
`endif
        end else if (valid[i]) begin
          timer_q[i] <= timer_q[i] + TIMEOUT_W'(1);
        end
      end
    end
  end

  // Registered receive status, timeout report and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_hit_o      <= '0;
      rec_err_o      <= '0;
      timeout_o      <= 1'b0;
      timeout_idx_o  <= '0;
      inflight_cnt_o <= '0;
      timeout_cnt_o  <= '0;
      max_latency_o  <= '0;
    end else begin
      rec_hit_o      <= port_hit;
      rec_err_o      <= rec_vld_i & ~port_hit;
      timeout_o      <= |expire;
      timeout_idx_o  <= to_idx;
      inflight_cnt_o <= inflight_nxt;
      timeout_cnt_o  <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
      if (|port_hit && (lat_max > max_latency_o)) max_latency_o <= lat_max;
    end
  end

`ifdef V_NOC_SB_TXN_ID_EN
  // Detect an accepted send reusing a live txn id from the same source.
  always_comb begin
    dup_now = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++)
      if (valid[i] && (src_q[i] == alloc_src_id_i) && (txn_q[i] == alloc_txn_id_i))
        dup_now = alloc_fire;
  end

  // Sticky duplicate-txn flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dup_txn <= 1'b0;
    else if (dup_now) dup_txn <= 1'b1;
  end

`ifndef SYNTHESIS
  // Flag duplicate txn ids loudly in simulation.
  always @(posedge clk)
    if (rst_n) assert (!dup_txn) else $error("duplicate txn id from same source");
`endif
`endif

endmodule

// File: tb/tb_v_noc_scoreboard_mp.sv
// Testbench for v_noc_scoreboard_mp: directed scenarios plus random traffic,
// checked each cycle against a deadline-based entry model.
module tb_v_noc_scoreboard_mp;
  localparam int E = 16, P = 2, TW = 15, DW = 32, NW = 4, XW = 8;
  localparam int AW = 4, CW = 5;

  logic clk, rst_n;
  logic alloc_vld_i, alloc_rdy_o;
  logic [NW-1:0] alloc_src_id_i, alloc_tgt_id_i;
  logic [XW-1:0] alloc_txn_id_i;
  logic [DW-1:0] alloc_data_i;
  logic [TW-1:0] alloc_timeout_i;
  logic [AW-1:0] alloc_idx_o;
  logic [P-1:0]  rec_vld_i;
  logic [P*NW-1:0] rec_id_i, rec_src_id_i;
  logic [P*XW-1:0] rec_txn_id_i;
  logic [P*DW-1:0] rec_data_i;
  logic [P-1:0]  rec_hit_o, rec_err_o;
  logic          timeout_o;
  logic [AW-1:0] timeout_idx_o;
  logic [CW-1:0] inflight_cnt_o;
  logic [31:0]   timeout_cnt_o;
  logic [63:0]   max_latency_o;

  v_noc_scoreboard_mp #(.ENTRY_NUM(E), .REC_PORT_NUM(P), .TIMEOUT_W(TW),
                        .DATA_W(DW), .NODE_ID_W(NW), .TXN_W(XW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_vld_i(alloc_vld_i), .alloc_rdy_o(alloc_rdy_o),
    .alloc_src_id_i(alloc_src_id_i), .alloc_tgt_id_i(alloc_tgt_id_i),
    .alloc_txn_id_i(alloc_txn_id_i), .alloc_data_i(alloc_data_i),
    .alloc_timeout_i(alloc_timeout_i), .alloc_idx_o(alloc_idx_o),
    .rec_vld_i(rec_vld_i), .rec_id_i(rec_id_i), .rec_src_id_i(rec_src_id_i),
    .rec_txn_id_i(rec_txn_id_i), .rec_data_i(rec_data_i),
    .rec_hit_o(rec_hit_o), .rec_err_o(rec_err_o),
    .timeout_o(timeout_o), .timeout_idx_o(timeout_idx_o),
    .inflight_cnt_o(inflight_cnt_o), .timeout_cnt_o(timeout_cnt_o),
    .max_latency_o(max_latency_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_bad;

  // Model: each live flit with its fields, send cycle and expiry deadline.
  bit              m_valid [E];
  logic [NW-1:0]   m_src [E], m_tgt [E];
  logic [DW-1:0]   m_data [E];
  logic [XW-1:0]   m_txn [E];
  longint unsigned m_sent [E], m_exp [E];
  bit              m_never [E];
  longint unsigned m_mc;
  logic [P-1:0]    e_hit, e_err;
  bit              e_to;
  int              e_to_idx, e_inflight;
  longint unsigned e_to_cnt, e_maxlat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < E; i++) m_valid[i] = 0;
    m_mc = 0; e_hit = '0; e_err = '0; e_to = 0; e_to_idx = 0;
    e_inflight = 0; e_to_cnt = 0; e_maxlat = 0;
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < E; i++) n += m_valid[i];
    return n;
  endfunction

  function automatic bit key_ok(int p, int i);
    bit ok;
    ok = m_tgt[i] == rec_id_i[p*NW +: NW] && m_src[i] == rec_src_id_i[p*NW +: NW] &&
         m_data[i] == rec_data_i[p*DW +: DW];
`ifdef V_NOC_SB_TXN_ID_EN
    ok = ok && (m_txn[i] == rec_txn_id_i[p*XW +: XW]);
`endif
    return ok;
  endfunction

  task automatic idle();
    alloc_vld_i = 0; alloc_src_id_i = '0; alloc_tgt_id_i = '0; alloc_txn_id_i = '0;
    alloc_data_i = '0; alloc_timeout_i = '0;
    rec_vld_i = '0; rec_id_i = '0; rec_src_id_i = '0; rec_txn_id_i = '0; rec_data_i = '0;
  endtask

  task automatic set_alloc(input int src, input int tgt, input int data, input int thr, input int txn);
    alloc_vld_i = 1; alloc_src_id_i = NW'(src); alloc_tgt_id_i = NW'(tgt);
    alloc_data_i = DW'(data); alloc_timeout_i = TW'(thr); alloc_txn_id_i = XW'(txn);
  endtask

  task automatic set_rec(input int p, input int id, input int src, input int data, input int txn);
    rec_vld_i[p] = 1'b1;
    rec_id_i[p*NW +: NW] = NW'(id);
    rec_src_id_i[p*NW +: NW] = NW'(src);
    rec_data_i[p*DW +: DW] = DW'(data);
    rec_txn_id_i[p*XW +: XW] = XW'(txn);
  endtask

  // One clock cycle: check comb outputs, advance the model, check registered outputs.
  task automatic tick();
    bit claimed [E];
    bit full, fire, any_hit;
    int fi, n_to, found;
    longint unsigned lat, best;
    #1;
    full = (m_count() == E);
    fi = 0;
    for (int i = E - 1; i >= 0; i--) if (!m_valid[i]) fi = i;
    fire = alloc_vld_i && !full;
    chk("alloc_rdy", 64'(alloc_rdy_o), 64'(!full));
    if (fire) chk("alloc_idx", 64'(alloc_idx_o), 64'(fi));
    for (int i = 0; i < E; i++) claimed[i] = 0;
    e_hit = '0; e_err = '0; best = 0; any_hit = 0;
    for (int p = 0; p < P; p++) if (rec_vld_i[p]) begin
      found = -1;
      for (int i = 0; i < E; i++)
        if (found < 0 && m_valid[i] && !claimed[i] && key_ok(p, i)) found = i;
      if (found >= 0) begin
        claimed[found] = 1; e_hit[p] = 1'b1; any_hit = 1;
        lat = m_mc - m_sent[found];
        if (lat > best) best = lat;
      end else e_err[p] = 1'b1;
    end
    e_to = 0; n_to = 0;
    for (int i = 0; i < E; i++)
      if (m_valid[i] && !m_never[i] && m_exp[i] == m_mc && !claimed[i]) begin
        if (!e_to) e_to_idx = i;
        e_to = 1; n_to++; m_valid[i] = 0;
      end
    for (int i = 0; i < E; i++) if (claimed[i]) m_valid[i] = 0;
    if (fire) begin
      m_valid[fi] = 1; m_src[fi] = alloc_src_id_i; m_tgt[fi] = alloc_tgt_id_i;
      m_data[fi] = alloc_data_i; m_txn[fi] = alloc_txn_id_i; m_sent[fi] = m_mc;
      m_never[fi] = (alloc_timeout_i == 0); m_exp[fi] = m_mc + alloc_timeout_i;
    end
    if (any_hit && best > e_maxlat) e_maxlat = best;
    e_to_cnt = e_to_cnt + n_to;
    if (e_to_cnt > 64'hFFFF_FFFF) e_to_cnt = 64'hFFFF_FFFF;
    e_inflight = m_count();
    m_mc++;
    @(posedge clk); @(negedge clk);
    chk("rec_hit", 64'(rec_hit_o), 64'(e_hit));
    chk("rec_err", 64'(rec_err_o), 64'(e_err));
    chk("timeout", 64'(timeout_o), 64'(e_to));
    if (e_to) chk("timeout_idx", 64'(timeout_idx_o), 64'(e_to_idx));
    chk("inflight", 64'(inflight_cnt_o), 64'(e_inflight));
    chk("timeout_cnt", 64'(timeout_cnt_o), e_to_cnt);
    chk("max_latency", max_latency_o, e_maxlat);
  endtask

  task automatic do_reset();
    rst_n = 0; idle(); model_reset();
    #1;
    chk("rst_rdy", 64'(alloc_rdy_o), 64'd1);
    chk("rst_inflight", 64'(inflight_cnt_o), 64'd0);
    chk("rst_hit_err", 64'({rec_hit_o, rec_err_o, timeout_o}), 64'd0);
    chk("rst_stats", 64'(timeout_cnt_o) | max_latency_o, 64'd0);
    @(negedge clk);
    rst_n = 1;
  endtask

  function automatic int pick_txn(int src);
    int t;
    bit clash;
    t = $urandom_range(0, 3);
`ifdef V_NOC_SB_TXN_ID_EN
    for (int k = 0; k < 256; k++) begin
      clash = 0;
      for (int i = 0; i < E; i++)
        if (m_valid[i] && m_src[i] == NW'(src) && m_txn[i] == XW'(t)) clash = 1;
      if (!clash) break;
      t = (t + 1) % 256;
    end
`else
    clash = 0;
`endif
    return t;
  endfunction

  initial begin
    int s, k;
    n_cmp = 0; n_bad = 0;
    rst_n = 0; idle(); model_reset();
    repeat (3) @(negedge clk);
    do_reset();

    // Single flit: latency 20.
    repeat (10) tick();
    set_alloc(1, 2, 'hA5, 100, 0); tick(); idle();
    chk("t1_inflight1", 64'(inflight_cnt_o), 64'd1);
    repeat (19) tick();
    set_rec(0, 2, 1, 'hA5, 0); tick(); idle();
    chk("t1_hit", 64'(rec_hit_o), 64'b01);
    chk("t1_inflight0", 64'(inflight_cnt_o), 64'd0);
    chk("t1_latency", max_latency_o, 64'd20);

    // Fill all entries, free index 5, regrant it.
    do_reset();
    for (int j = 0; j < E; j++) begin set_alloc(1, 2, j, 0, j); tick(); end
    idle(); #1;
    chk("t2_full_rdy", 64'(alloc_rdy_o), 64'd0);
    set_alloc(1, 2, 99, 0, 99); tick(); idle();
    set_rec(0, 2, 1, 5, 5); tick(); idle(); #1;
    chk("t2_rdy_again", 64'(alloc_rdy_o), 64'd1);
    set_alloc(3, 3, 50, 0, 50); #1;
    chk("t2_regrant", 64'(alloc_idx_o), 64'd5);
    tick(); idle();

    // Timeout with threshold 3; threshold 0 never expires.
    do_reset();
    set_alloc(2, 3, 7, 3, 0); tick(); idle();
    tick(); tick();
    chk("t3_no_to_yet", 64'(timeout_o), 64'd0);
    tick();
    chk("t3_to", 64'(timeout_o), 64'd1);
    chk("t3_to_idx", 64'(timeout_idx_o), 64'd0);
    chk("t3_to_cnt", 64'(timeout_cnt_o), 64'd1);
    set_alloc(2, 3, 8, 0, 1); tick(); idle();
    repeat (1000) tick();
    chk("t3_never", 64'(inflight_cnt_o), 64'd1);
    chk("t3_cnt_hold", 64'(timeout_cnt_o), 64'd1);

    // Two ports, same flit.
    do_reset();
    set_alloc(3, 4, 77, 0, 1); tick(); set_alloc(3, 4, 77, 0, 2); tick(); idle();
    set_rec(0, 4, 3, 77, 1); set_rec(1, 4, 3, 77, 2); tick(); idle();
    chk("t4_both_hit", 64'(rec_hit_o), 64'b11);
    chk("t4_inflight", 64'(inflight_cnt_o), 64'd0);
    set_alloc(3, 4, 77, 0, 1); tick(); idle();
    set_rec(0, 4, 3, 77, 1); set_rec(1, 4, 3, 77, 1); tick(); idle();
    chk("t4_one_hit", 64'(rec_hit_o), 64'b01);
    chk("t4_one_err", 64'(rec_err_o), 64'b10);

    // Receive on the expiry cycle: hit wins.
    do_reset();
    set_alloc(5, 6, 'h33, 4, 0); tick(); idle();
    repeat (3) tick();
    set_rec(0, 6, 5, 'h33, 0); tick(); idle();
    chk("t5_hit", 64'(rec_hit_o), 64'b01);
    chk("t5_no_to", 64'(timeout_o), 64'd0);
    chk("t5_cnt", 64'(timeout_cnt_o), 64'd0);

`ifdef V_NOC_SB_TXN_ID_EN
    do_reset();
    set_alloc(1, 2, 9, 0, 3); tick(); set_alloc(1, 2, 9, 0, 7); tick(); idle();
    set_rec(0, 2, 1, 9, 7); tick(); idle();
    chk("tx_hit7", 64'(rec_hit_o), 64'b01);
    set_rec(0, 2, 1, 9, 9); tick(); idle();
    chk("tx_err9", 64'(rec_err_o), 64'b01);
    set_alloc(1, 2, 9, 0, 8); #1;
    chk("tx_idx1_free", 64'(alloc_idx_o), 64'd1);
    tick(); idle();
`endif

    // Random traffic with occasional mid-run resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit heavy;
      heavy = ((c / 200) % 3) == 1;
      idle();
      if ($urandom_range(0, 99) < (heavy ? 90 : 45)) begin
        s = $urandom_range(0, 3);
        set_alloc(s, $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30), pick_txn(s));
      end
      for (int p = 0; p < P; p++)
        if ($urandom_range(0, 99) < (heavy ? 15 : 60)) begin
          k = $urandom_range(0, E - 1);
          if (p == 1 && rec_vld_i[0] && $urandom_range(0, 2) == 0) begin
            set_rec(1, rec_id_i[NW-1:0], rec_src_id_i[NW-1:0], rec_data_i[DW-1:0],
                    rec_txn_id_i[XW-1:0]);
          end else if (m_valid[k] && $urandom_range(0, 9) < 7) begin
            set_rec(p, m_tgt[k], m_src[k], m_data[k], m_txn[k]);
          end else begin
            set_rec(p, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3));
          end
        end
      if (c % 750 == 749) do_reset();
      else tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/v_noc_scoreboard_mp.md
Name: v_noc_scoreboard_mp

Overview:
Parametrised multi-port NoC test scoreboard. It tracks in-flight flits from injection to ejection and sits in the NoC testbench between the test-case senders and the per-node receivers. Each send allocates an entry. Each received flit is matched against the outstanding entries and frees the entry it hits. Stuck flits are retired by per-entry timeout counters, and inflight, timeout and latency statistics are kept.

Parameters:
ENTRY_NUM, 16, number of outstanding entries (≥2)
REC_PORT_NUM, 2, number of receive ports checked in parallel (≥1)
TIMEOUT_W, 15, width of per-entry timeout counter and threshold
DATA_W, 32, flit payload width
NODE_ID_W, 4, node id width
TXN_W, 8, transaction id width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alloc_vld_i  in  1  send request
alloc_rdy_o  out  1  a free entry exists
alloc_src_id_i  in  NODE_ID_W  source node
alloc_tgt_id_i  in  NODE_ID_W  target node
alloc_txn_id_i  in  TXN_W  transaction id (used only with the optional feature)
alloc_data_i  in  DATA_W  payload
alloc_timeout_i  in  TIMEOUT_W  timeout threshold; 0 = never time out
alloc_idx_o  out  $clog2(ENTRY_NUM)  index granted this cycle
rec_vld_i  in  REC_PORT_NUM  receive valid per port
rec_id_i  in  REC_PORT_NUM*NODE_ID_W  receiving node
rec_src_id_i  in  REC_PORT_NUM*NODE_ID_W  flit source id
rec_txn_id_i  in  REC_PORT_NUM*TXN_W  flit txn id
rec_data_i  in  REC_PORT_NUM*DATA_W  flit payload
rec_hit_o  out  REC_PORT_NUM  registered; port matched an entry
rec_err_o  out  REC_PORT_NUM  registered; port had no match or a duplicate match
timeout_o  out  1  registered pulse; at least one entry timed out
timeout_idx_o  out  $clog2(ENTRY_NUM)  lowest timed-out index
inflight_cnt_o  out  $clog2(ENTRY_NUM)+1  valid entry count
timeout_cnt_o  out  32  saturating total of timed-out entries
max_latency_o  out  64  maximum observed send-to-receive latency, in cycles

Behaviour:
- Reset (async, rst_n=0):
  - all entries invalid
  - free-running 64-bit mcycle = 0
  - all outputs 0, except alloc_rdy_o = 1
- Allocation:
  - alloc_rdy_o = ~&valid, using registered valid only.
  - On alloc_vld_i & alloc_rdy_o, the lowest free index is granted combinationally on alloc_idx_o.
  - The granted entry stores ids, data, threshold and sent_mcycle = current mcycle. It becomes valid next cycle, with timer = 0.
  - An entry freed in cycle N is not allocatable until N+1.
- Match, per port p, when rec_vld_i[p]:
  - Candidates: valid entries with tgt_id == rec_id[p], src_id == rec_src_id[p] and data == rec_data[p].
  - Among candidates, the lowest index matches.
  - A port with no candidate → rec_err_o[p] = 1 next cycle.
- Simultaneous receives:
  - If several ports select the same entry, the lowest-numbered port hits.
  - Each higher port retries on its next candidate entry not already claimed.
  - A port left without any entry → rec_err_o[p] = 1.
- Hit handling:
  - The hit entry is freed at the clock edge.
  - rec_hit_o[p] = 1 the following cycle (1-cycle latency).
  - latency = mcycle − sent_mcycle, unsigned 64-bit.
  - max_latency_o updates to the max over all hits that cycle, if it exceeds the current value.
- Timeout:
  - Each valid entry's timer increments every cycle.
  - When timer+1 == threshold (threshold ≠ 0), the entry is freed.
  - timeout_o = 1 and timeout_idx_o = lowest such index, on the next cycle.
  - timeout_cnt_o += number of entries timed out that cycle, saturating at 2^32−1.
  - If a receive hits an entry in the same cycle it would time out, the hit wins: no timeout is reported.
- Counters:
  - inflight_cnt_o is registered = popcount(valid).
  - Same-cycle allocate + free keeps the count consistent.
  - Full and empty are both legal steady states.
- Reset mid-operation clears all entries and statistics immediately; in-flight receives are dropped.

Optional Feature:
Macro V_NOC_SB_TXN_ID_EN.
- Defined: the txn id is stored per entry and is part of the match key (rec_txn_id == txn_id, in addition to src/tgt/data). alloc_vld_i with a txn_id equal to that of a valid entry with the same src_id → the allocation is still accepted, and a sticky dup_txn error bit is set internally and asserted under simulation.
- Undefined: txn id inputs are ignored and not stored; matching uses src/tgt/data only.

Test Plan:
- Reset, then one alloc (src=1, tgt=2, data=0xA5, thr=100) at mcycle 10; receive on port0 at mcycle 30 → rec_hit_o[0]=1 at 31, inflight 1→0, max_latency_o=20.
- Allocate 16 entries back-to-back → alloc_rdy_o=0 after 16th; a receive frees index 5 → alloc_rdy_o=1 next cycle and the next grant is idx 5.
- Alloc thr=3, no receive → timeout_o pulse 3 cycles after valid, timeout_idx_o=0, timeout_cnt_o=1; thr=0 entry never times out in 1000 cycles.
- Two identical entries (idx 0,1) and both ports receiving the same flit in one cycle → both hit (port0→idx0, port1→idx1), inflight 0; with only one entry, port1 gets rec_err_o=1.
- Receive arriving the exact cycle the timer expires → rec_hit_o=1, timeout_o=0, timeout_cnt_o unchanged.
- With V_NOC_SB_TXN_ID_EN: two entries differing only in txn (3, 7); receive txn 7 → idx1 freed; receive txn 9 → rec_err_o=1.
